// File: rtl/booth_pp_sequencer.sv
// Radix-8 modified-Booth partial-product sequencer.
// Latches an unsigned operand pair and precomputes the multiples 1A..4A, with 3A
// taken from a registered adder. It then emits the multiplier's one-hot Booth digits
// one per pp_valid/pp_ready handshake.
// Optional feature macro: BOOTH_ZERO_SKIP_EN emits only the nonzero digits.
module booth_pp_sequencer #(
   parameter int unsigned WIDTH = 24
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [WIDTH-1:0]   a,
   input  logic [WIDTH-1:0]   b,
   output logic [WIDTH+1:0]   x1,
   output logic [WIDTH+1:0]   x2,
   output logic [WIDTH+1:0]   x3,
   output logic [WIDTH+1:0]   x4,
   output logic [4:0]         y,
   output logic               pp_neg,
   output logic [3:0]         pp_idx,
   output logic               pp_valid,
   input  logic               pp_ready,
   output logic               pp_last
);

   localparam int unsigned MW   = WIDTH + 2;
   localparam int unsigned NDIG = WIDTH / 3 + 1;
   localparam int unsigned BW   = 3 * NDIG + 1;
   localparam int unsigned IW   = 4;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_PREP = 2'd1,
      S_EMIT = 2'd2
   } state_t;

   state_t          state_q;
   logic [MW-1:0]   x1_q, x2_q, x3_q, x4_q;
   logic [BW-1:0]   bext_q;
   logic [NDIG-1:0] rem_q;
   logic [4:0]      y_q;
   logic            pp_neg_q;
   logic [IW-1:0]   pp_idx_q;
   logic            pp_valid_q;
   logic            pp_last_q;

   logic [BW-1:0]   bext_c;
   logic [NDIG-1:0] mask_c;
   logic [IW-1:0]   nxt_idx_c;
   logic [NDIG-1:0] rem_nxt_c;
   logic [3:0]      grp_c;
   logic [4:0]      code_c;

   // One-hot {neg,4x,3x,2x,1x} code for a 4-bit overlapping Booth group.
   function automatic logic [4:0] booth_code(input logic [3:0] g);
      logic [4:0] c;
      c = 5'b00000;
      case (g)
         4'b0001, 4'b0010: c = 5'b00001;
         4'b0011, 4'b0100: c = 5'b00010;
         4'b0101, 4'b0110: c = 5'b00100;
         4'b0111:          c = 5'b01000;
         4'b1000:          c = 5'b11000;
         4'b1001, 4'b1010: c = 5'b10100;
         4'b1011, 4'b1100: c = 5'b10010;
         4'b1101, 4'b1110: c = 5'b10001;
         default:          c = 5'b00000;
      endcase
      return c;
   endfunction

   // Multiplier with the implicit zero below the LSB and zero padding on top.
   assign bext_c = BW'({b, 1'b0});

   // Set of digit indices to emit for the pair being accepted.
   always_comb begin
`ifdef BOOTH_ZERO_SKIP_EN
      mask_c = '0;
      for (int i = 0; i < int'(NDIG); i++) begin
         mask_c[i] = (bext_c[3*i +: 4] != 4'b0000) && (bext_c[3*i +: 4] != 4'b1111);
      end
`else
      mask_c = '1;
`endif
   end

   // Lowest pending digit, its Booth code, and the pending set once it is consumed.
   // An empty set (b==0 with skipping) falls back to index 0, whose code is zero.
   always_comb begin
      nxt_idx_c = '0;
      for (int i = int'(NDIG) - 1; i >= 0; i--) begin
         if (rem_q[i]) nxt_idx_c = IW'(i);
      end
      rem_nxt_c = rem_q & ~(NDIG'(1) << nxt_idx_c);
      grp_c     = 4'(bext_q >> (3 * nxt_idx_c));
      code_c    = booth_code(grp_c);
   end

   assign in_ready = (state_q == S_IDLE) && !rst;

   // Sequencer: accepts the pair, prepares 3A, then steps through the digits on each handshake.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= S_IDLE;
         x1_q       <= '0;
         x2_q       <= '0;
         x3_q       <= '0;
         x4_q       <= '0;
         bext_q     <= '0;
         rem_q      <= '0;
         y_q        <= '0;
         pp_neg_q   <= 1'b0;
         pp_idx_q   <= '0;
         pp_valid_q <= 1'b0;
         pp_last_q  <= 1'b0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (in_valid && in_ready) begin
                  x1_q    <= MW'(a);
                  x2_q    <= MW'({a, 1'b0});
                  x4_q    <= MW'({a, 2'b00});
                  bext_q  <= bext_c;
                  rem_q   <= mask_c;
                  state_q <= S_PREP;
               end
            end
            S_PREP: begin
               x3_q       <= x1_q + x2_q;
               y_q        <= code_c;
               pp_neg_q   <= code_c[4];
               pp_idx_q   <= nxt_idx_c;
               pp_last_q  <= (rem_nxt_c == '0);
               pp_valid_q <= 1'b1;
               rem_q      <= rem_nxt_c;
               state_q    <= S_EMIT;
            end
            S_EMIT: begin
               if (pp_ready) begin
                  if (pp_last_q) begin
                     y_q        <= '0;
                     pp_neg_q   <= 1'b0;
                     pp_idx_q   <= '0;
                     pp_last_q  <= 1'b0;
                     pp_valid_q <= 1'b0;
                     state_q    <= S_IDLE;
                  end else begin
                     y_q        <= code_c;
                     pp_neg_q   <= code_c[4];
                     pp_idx_q   <= nxt_idx_c;
                     pp_last_q  <= (rem_nxt_c == '0);
                     rem_q      <= rem_nxt_c;
                  end
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign x1       = x1_q;
   assign x2       = x2_q;
   assign x3       = x3_q;
   assign x4       = x4_q;
   assign y        = y_q;
   assign pp_neg   = pp_neg_q;
   assign pp_idx   = pp_idx_q;
   assign pp_valid = pp_valid_q;
   assign pp_last  = pp_last_q;

endmodule

// File: doc/booth_pp_sequencer.md
# booth_pp_sequencer

Sequential partial-product front end of the radix-8 modified-Booth multiplier. Accepts one unsigned multiplicand/multiplier pair per transaction and precomputes the multiples 1A, 2A, 3A and 4A; 3A uses a registered adder. It then emits the multiplier's radix-8 Booth digits one per handshake as one-hot 5-bit codes, together with the multiples, directly into the Booth selector. Downstream logic adds the selected partial products and applies the +1 correction flagged by `pp_neg`.

## Interface
- `WIDTH`, default 24: operand width. Multiples are `WIDTH+2` bits wide. The digit count is `NDIG = WIDTH/3 + 1` (9 at the default).
- `clk`  in  1  clock. All state updates on the rising edge.
- `rst`  in  1  reset. One clock; reset is synchronous and active-high.
- `in_valid`  in  1  operand pair valid.
- `in_ready`  out  1  block idle; can accept an operand pair.
- `a`  in  WIDTH  multiplicand (unsigned).
- `b`  in  WIDTH  multiplier (unsigned).
- `x1`, `x2`, `x3`, `x4`  out  WIDTH+2 each  1A, 2A, 3A, 4A, zero-extended.
- `y`  out  5  one-hot Booth code `{neg,4x,3x,2x,1x}`.
- `pp_neg`  out  1  equals `y[4]`; the downstream stage adds +1 at this digit's weight.
- `pp_idx`  out  4  digit index; weight is 8^`pp_idx`.
- `pp_valid`  out  1  digit presented.
- `pp_ready`  in  1  downstream accepts the digit.
- `pp_last`  out  1  presented digit is the final one of the transaction.

## Operation
- States:
  - IDLE: `in_ready`=1.
  - PREP: 1 cycle; registers `x3` = `a` + (`a`<<1).
  - EMIT: presents digits.
- Transitions:
  - IDLE → PREP on `in_valid`&`in_ready`. On that edge: latch `a`; load `x1`=`a`, `x2`=`a`<<1, `x4`=`a`<<2; load `bext` = {pad zeros, `b`, 1'b0}, 3·NDIG+1 bits.
  - PREP → EMIT unconditionally.
  - EMIT: advances `pp_idx` on `pp_valid`&`pp_ready`. After the `pp_last` digit is accepted, returns to IDLE.
- Digit i is taken from group g = `bext[3i+3:3i]`; its value is −4·g3 + 2·g2 + g1 + g0. Codes:
  - 0 → 00000
  - +1 → 00001, +2 → 00010, +3 → 00100, +4 → 01000
  - −1 → 10001, −2 → 10010, −3 → 10100, −4 → 11000
  - Groups 0000 and 1111 both map to 00000; a zero digit never has neg set.
- Because of the zero padding, digit NDIG−1 is never negative.
- Multiples are zero-extended and never overflow: 3·(2^WIDTH−1) < 2^(WIDTH+2).
- `x1`..`x4` hold from PREP until the next accept. The selector sees stable multiples for the whole transaction.
- While `pp_valid`=1 and `pp_ready`=0, `y`, `pp_neg`, `pp_idx` and `pp_last` hold.
- No new transaction is accepted until the previous one completes; `in_ready`=0 in PREP and EMIT.
- Reset values: state IDLE; `in_ready`=0 during the reset cycle and 1 afterwards. `pp_valid`, `pp_last`, `pp_neg`=0; `y`=0; `pp_idx`=0; `x1`..`x4`=0.
- Reset asserted mid-transaction aborts it. The next cycle shows IDLE, `pp_valid`=0 and all outputs at reset values. No partial digits are emitted afterwards.

## Timing
- Accept edge T: state PREP during T+1. First digit has `pp_valid`=1 from T+2.
- With `pp_ready` held at 1, one digit is accepted per cycle. `pp_last` is at T+2+NDIG−1 (T+10 at the default). `in_ready`=1 on the following cycle.
- `pp_ready` is registered only through the index advance. It has no combinational path to `in_ready` or `y`.

## Configuration
- `BOOTH_ZERO_SKIP_EN` defined:
  - At accept, a registered NDIG-bit nonzero mask is computed.
  - EMIT presents only nonzero digits, lowest first; `pp_idx` carries the true digit index.
  - `pp_last` marks the highest nonzero digit.
  - If `b`=0, a single digit is emitted: `pp_idx`=0, `y`=00000, `pp_last`=1.
- `BOOTH_ZERO_SKIP_EN` undefined: all NDIG digits are emitted in order, `pp_last` on index NDIG−1.

## Test plan
- `a`=0x000001, `b`=0x000007, `pp_ready`=1 → `x3`=0x3.
  - idx0 `y`=10001, `pp_neg`=1; idx1 `y`=00001; idx2..8 `y`=00000.
  - `pp_last` at idx8, cycle T+10.
- `a`=`b`=0xFFFFFF → `x1`=0x0FFFFFF, `x2`=0x1FFFFFE, `x3`=0x2FFFFFD, `x4`=0x3FFFFFC.
  - idx0 `y`=10001; idx1..7 `y`=00000; idx8 `y`=00001, `pp_last`=1.
- `b`=0x000003 → idx0 `y`=00100. Separate transaction with `b`=0x000004 → idx0 `y`=11000, idx1 `y`=00001.
- `b`=0x000007, `pp_ready` low for 3 cycles while idx2 is presented → `y`, `pp_idx`=2, `pp_last`=0 stable; `in_ready`=0; `in_valid` pulses ignored.
- `rst` asserted during EMIT at idx4 → next cycle `pp_valid`=0, `in_ready`=1, `x1`..`x4`=0. A new pair accepted afterwards emits a correct sequence starting at idx0.
- Build with `BOOTH_ZERO_SKIP_EN`:
  - `b`=0x000007 → exactly two digits: idx0 10001, then idx1 00001 with `pp_last`=1.
  - `b`=0 → one digit: idx0, `y`=00000, `pp_last`=1.
